// File: rtl/pipe_flow_ctrl_gen.sv
// Pipeline flow controller: per-stage WORK/STOP/REFRESH codes from prioritised hold, interrupt and
// redirect inputs, with a RUN/DRAIN/HALTED debug-halt FSM, stall watchdog and perf counters.
`ifndef FLOW_WIDTH
`define FLOW_WIDTH 2
`endif
`ifndef FLOW_WORK
`define FLOW_WORK 2'd0
`endif
`ifndef FLOW_STOP
`define FLOW_STOP 2'd1
`endif
`ifndef FLOW_REFRESH
`define FLOW_REFRESH 2'd2
`endif
`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif

module pipe_flow_ctrl_gen #(
    parameter int NUM_STAGES = 5,
    parameter int NUM_SRC    = 6,
    parameter logic [NUM_SRC*NUM_STAGES-1:0] SRC_STOP_MASK  = 30'b00001_00111_00011_00111_01111_11111,
    parameter logic [NUM_SRC*NUM_STAGES-1:0] SRC_FLUSH_MASK = 30'b00010_01000_00100_01000_10000_00000,
    parameter int REDIR_FLUSH = 2,
    parameter int TIMEOUT     = 1024,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_SRC-1:0]                hold_req_i,
    input  logic                              int_assert_i,
    input  logic [`CPU_WIDTH-1:0]             int_addr_i,
    input  logic                              redirect_i,
    input  logic [`CPU_WIDTH-1:0]             redirect_pc_i,
    input  logic                              halt_req_i,
    output logic                              halt_ack_o,
    output logic [`CPU_WIDTH-1:0]             next_pc_o,
    output logic                              next_pc_four_o,
    output logic [NUM_STAGES*`FLOW_WIDTH-1:0] flow_o,
    output logic                              stall_timeout_o,
    output logic [CNT_WIDTH-1:0]              stall_cycles_o,
    output logic [CNT_WIDTH-1:0]              flush_cnt_o
);

    localparam int FW  = `FLOW_WIDTH;
    localparam int DCW = $clog2(NUM_STAGES) + 1;
    localparam int SCW = $clog2(TIMEOUT + 1);
    // Value of drain_cnt on the final drain cycle before entering HALTED.
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(NUM_STAGES - 3);
    localparam logic [SCW-1:0] STALL_MAX  = SCW'(TIMEOUT);
    localparam logic [SCW-1:0] STALL_TRIP = SCW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_HALTED
    } state_t;

    typedef enum logic [2:0] {
        PAT_RST,
        PAT_HALT,
        PAT_INT,
        PAT_HOLD,
        PAT_REDIR,
        PAT_DRAIN,
        PAT_NORM
    } pat_t;

    state_t               state_reg, state_next;
    logic [DCW-1:0]       drain_cnt_reg, drain_cnt_next;
    logic                 halt_ack_reg;
    logic [SCW-1:0]       stall_cnt_reg;
    logic                 stall_timeout_reg;
    logic [CNT_WIDTH-1:0] stall_cycles_reg;
    logic [CNT_WIDTH-1:0] flush_cnt_reg;

    pat_t                 pat;
    logic [NUM_SRC-1:0]   first_hot;
    logic                 hold_any;
    logic                 stalled;

    // One-hot of the lowest-index (highest-priority) active hold source.
    always_comb begin
        first_hot = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (hold_req_i[k]) begin
                first_hot    = '0;
                first_hot[k] = 1'b1;
            end
        end
    end

    assign hold_any = |hold_req_i;

    always_comb begin
        pat = PAT_NORM;
        if (rst)                          pat = PAT_RST;
        else if (state_reg == ST_HALTED)  pat = PAT_HALT;
        else if (int_assert_i)            pat = PAT_INT;
        else if (hold_any)                pat = PAT_HOLD;
        else if (redirect_i)              pat = PAT_REDIR;
        else if (state_reg == ST_DRAIN)   pat = PAT_DRAIN;
    end

    always_comb begin
        next_pc_o      = '0;
        next_pc_four_o = 1'b0;
        case (pat)
            PAT_INT:   next_pc_o      = int_addr_i;
            PAT_REDIR: next_pc_o      = redirect_pc_i;
            PAT_NORM:  next_pc_four_o = 1'b1;
            default: ;
        endcase
    end

    genvar gi, gk;
    generate
        for (gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
            logic [NUM_SRC-1:0] stop_col;
            logic [NUM_SRC-1:0] flush_col;
            logic [FW-1:0]      code;

            for (gk = 0; gk < NUM_SRC; gk++) begin : g_src
                assign stop_col[gk]  = SRC_STOP_MASK[gk*NUM_STAGES + gi];
                assign flush_col[gk] = SRC_FLUSH_MASK[gk*NUM_STAGES + gi];
            end

            always_comb begin
                code = `FLOW_WORK;
                case (pat)
                    PAT_RST:   code = `FLOW_REFRESH;
                    PAT_HALT:  code = `FLOW_STOP;
                    PAT_INT:   code = (gi == 0) ? `FLOW_WORK : `FLOW_REFRESH;
                    PAT_HOLD: begin
                        // Flush bit takes precedence over stop bit for the same source.
                        if (|(first_hot & flush_col))     code = `FLOW_REFRESH;
                        else if (|(first_hot & stop_col)) code = `FLOW_STOP;
                        else                              code = `FLOW_WORK;
                    end
                    PAT_REDIR: code = (gi >= 1 && gi <= REDIR_FLUSH) ? `FLOW_REFRESH : `FLOW_WORK;
                    PAT_DRAIN: begin
                        if (gi == 0)      code = `FLOW_STOP;
                        else if (gi == 1) code = `FLOW_REFRESH;
                        else              code = `FLOW_WORK;
                    end
                    default:   code = `FLOW_WORK;
                endcase
            end

            assign flow_o[gi*FW +: FW] = code;
        end
    endgenerate

    always_comb begin
        state_next     = state_reg;
        drain_cnt_next = drain_cnt_reg;
        case (state_reg)
            ST_RUN: begin
                if (halt_req_i) begin
                    state_next     = ST_DRAIN;
                    drain_cnt_next = '0;
                end
            end
            ST_DRAIN: begin
                if (!halt_req_i) begin
                    state_next     = ST_RUN;
                    drain_cnt_next = '0;
                end else if (pat == PAT_INT || pat == PAT_REDIR) begin
                    drain_cnt_next = '0;
                end else if (pat == PAT_DRAIN) begin
                    drain_cnt_next = drain_cnt_reg + 1'b1;
                    if (drain_cnt_reg == DRAIN_LAST) state_next = ST_HALTED;
                end
            end
            ST_HALTED: begin
                if (!halt_req_i) state_next = ST_RUN;
            end
            default: state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_RUN;
            drain_cnt_reg <= '0;
            halt_ack_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            drain_cnt_reg <= drain_cnt_next;
            halt_ack_reg  <= (state_next == ST_HALTED);
        end
    end

    // Watchdog ignores HALTED: a deliberate debug stop is not a hang.
    assign stalled = (state_reg != ST_HALTED) && (flow_o[FW-1:0] != `FLOW_WORK);

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_reg     <= '0;
            stall_timeout_reg <= 1'b0;
        end else if (stalled) begin
            if (stall_cnt_reg != STALL_MAX) stall_cnt_reg <= stall_cnt_reg + 1'b1;
            stall_timeout_reg <= (stall_cnt_reg >= STALL_TRIP);
        end else begin
            stall_cnt_reg     <= '0;
            stall_timeout_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_reg <= '0;
            flush_cnt_reg    <= '0;
        end else begin
            if (hold_any) stall_cycles_reg <= stall_cycles_reg + 1'b1;
            if (pat == PAT_INT || pat == PAT_REDIR) flush_cnt_reg <= flush_cnt_reg + 1'b1;
        end
    end

    assign halt_ack_o      = halt_ack_reg;
    assign stall_timeout_o = stall_timeout_reg;
    assign stall_cycles_o  = stall_cycles_reg;
    assign flush_cnt_o     = flush_cnt_reg;

endmodule
